// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction fetch memory: fault codes,
// the default fill word and the INIT/RUN state encoding.
package inst_mem_pkg;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // ADDI x0,x0,0 -- harmless filler and the payload of faulted responses
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0013;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } FetchState;

endpackage

// File: rtl/inst_mem_array.sv
// Word-wide instruction storage with one write port and one registered
// read port. Words are kept exactly as written, so bit [7:0] of a word is
// the byte at the lowest address (little-endian within the word).
module inst_mem_array #(
  parameter int WORDS = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_wAddr,
  input  logic [31:0]      i_wData,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_rAddr,
  output logic [31:0]      o_rData
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rData;

  // Write port: no reset, the owner fills the array with NOPs after reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wAddr] <= i_wData;
    end
  end

  // Read port: the data register only moves on a read, so it holds between fetches
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rData <= r_mem[i_rAddr];
    end
  end

  assign o_rData = r_rData;

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction memory with a valid/ready fetch port, a program-load port,
// NOP self-initialisation after reset and misaligned/out-of-range faults.
module inst_fetch_mem
  import inst_mem_pkg::*;
#(
  parameter int          MEM_SIZE_BYTES = 1024,
  parameter int          ADDR_WIDTH     = 32,
  parameter logic [31:0] NOP_WORD       = DEFAULT_NOP_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_pc,
  output logic [1:0]            rsp_fault,
  input  logic                  flush,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]           prog_data,
  output logic                  prog_ready
);

  localparam int WORDS   = MEM_SIZE_BYTES / 4;
  localparam int IDX_W   = $clog2(WORDS);
  localparam int IDX_MSB = IDX_W + 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD_PC = ADDR_WIDTH'(MEM_SIZE_BYTES - 4);
  localparam logic [ADDR_WIDTH-1:0] MEM_END      = ADDR_WIDTH'(MEM_SIZE_BYTES);
  localparam logic [IDX_W-1:0]      LAST_IDX     = IDX_W'(WORDS - 1);

  FetchState        r_state;
  FetchState        w_nextState;
  logic [IDX_W-1:0] r_initIdx;
  logic [IDX_W-1:0] w_nextInitIdx;

  logic             w_run;
  logic             w_accept;
  logic [1:0]       w_reqFault;
  logic             w_progInRange;

  logic             w_arrWe;
  logic [IDX_W-1:0] w_arrWAddr;
  logic [31:0]      w_arrWData;
  logic             w_arrRe;
  logic [31:0]      w_arrRData;

  logic                  r_rspValid;
  logic [ADDR_WIDTH-1:0] r_rspPc;
  logic [1:0]            r_rspFault;
  logic                  r_rspFromArray;

  // State register and init word counter; reset restarts the NOP fill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= INIT;
      r_initIdx <= '0;
    end else begin
      r_state   <= w_nextState;
      r_initIdx <= w_nextInitIdx;
    end
  end

  // INIT walks every word once, then hands over to RUN for good
  always_comb begin
    w_nextState   = r_state;
    w_nextInitIdx = r_initIdx;
    if (r_state == INIT) begin
      w_nextInitIdx = r_initIdx + 1'b1;
      if (r_initIdx == LAST_IDX) begin
        w_nextState = RUN;
      end
    end
  end

  assign w_run      = (r_state == RUN);
  assign prog_ready = w_run;

  // A program write steals the cycle so a fetch never reads a word being written
  assign req_ready = w_run & ~prog_we & (~r_rspValid | rsp_ready);
  assign w_accept  = req_valid & req_ready;

  // Misalignment is reported ahead of range so a bad low pair always shows
  always_comb begin
    w_reqFault = FAULT_NONE;
    if (req_pc[1:0] != 2'b00) begin
      w_reqFault = FAULT_MISALIGN;
    end else if (req_pc > LAST_WORD_PC) begin
      w_reqFault = FAULT_RANGE;
    end
  end

  assign w_progInRange = (prog_addr < MEM_END);

  // Write port is owned by the fill walker in INIT and by program loads in RUN
  always_comb begin
    w_arrWe    = 1'b0;
    w_arrWAddr = r_initIdx;
    w_arrWData = NOP_WORD;
    if (r_state == INIT) begin
      w_arrWe = 1'b1;
    end else if (prog_we && w_progInRange) begin
      w_arrWe    = 1'b1;
      w_arrWAddr = prog_addr[IDX_MSB:2];
      w_arrWData = prog_data;
    end
  end

  assign w_arrRe = w_accept & (w_reqFault == FAULT_NONE);

  inst_mem_array #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arrWe),
    .i_wAddr (w_arrWAddr),
    .i_wData (w_arrWData),
    .i_re    (w_arrRe),
    .i_rAddr (req_pc[IDX_MSB:2]),
    .o_rData (w_arrRData)
  );

  // Response register: a new accept overrides flush, otherwise consume or flush drops it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rspValid     <= 1'b0;
      r_rspPc        <= '0;
      r_rspFault     <= FAULT_NONE;
      r_rspFromArray <= 1'b0;
    end else if (w_accept) begin
      r_rspValid     <= 1'b1;
      r_rspPc        <= req_pc;
      r_rspFault     <= w_reqFault;
      r_rspFromArray <= (w_reqFault == FAULT_NONE);
    end else if (rsp_ready || flush) begin
      r_rspValid <= 1'b0;
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_pc    = r_rspPc;
  assign rsp_fault = r_rspFault;
  assign rsp_instr = r_rspFromArray ? w_arrRData : NOP_WORD;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Directed bench for inst_fetch_mem: a word-level memory model predicts
// every cycle's outputs, and literal expectations pin key scenarios.
module tb_inst_fetch_mem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic [1:0]  rsp_fault;
  logic        flush;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        prog_ready;

  int checks   = 0;
  int failures = 0;

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  inst_fetch_mem #(
    .MEM_SIZE_BYTES (1024),
    .ADDR_WIDTH     (32),
    .NOP_WORD       (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_instr  (rsp_instr),
    .rsp_pc     (rsp_pc),
    .rsp_fault  (rsp_fault),
    .flush      (flush),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_ready (prog_ready)
  );

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Behavioural model: a plain word array plus one pending response slot
  logic [31:0] modelMem [256];
  int          initEdges;
  bit          expValid;
  logic [31:0] expInstr;
  logic [31:0] expPc;
  logic [1:0]  expFault;
  bit          modelAccept;

  // Model advances on the same edges as the design, reset clears it at once
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      initEdges = 0;
      expValid  = 1'b0;
      expInstr  = NOP;
      expPc     = 32'h0;
      expFault  = 2'd0;
      for (int i = 0; i < 256; i++) modelMem[i] = NOP;
    end else if (initEdges < 256) begin
      initEdges++;
    end else begin
      modelAccept = req_valid && !prog_we && (!expValid || rsp_ready);
      if (prog_we && prog_addr < 32'd1024) modelMem[prog_addr / 4] = prog_data;
      if (modelAccept) begin
        expValid = 1'b1;
        expPc    = req_pc;
        if (req_pc % 4 != 0) begin
          expFault = 2'd1;
          expInstr = NOP;
        end else if (req_pc > 32'd1020) begin
          expFault = 2'd2;
          expInstr = NOP;
        end else begin
          expFault = 2'd0;
          expInstr = modelMem[req_pc / 4];
        end
      end else if (rsp_ready || flush) begin
        expValid = 1'b0;
      end
    end
  end

  bit          logging = 1'b0;
  logic [31:0] logPc [$];
  logic [31:0] logInstr [$];
  logic [31:0] streamPc [3];
  logic [31:0] streamInstr [3];

  // Compare process: every falling edge, outputs against the model
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_instr", rsp_instr, NOP);
      checkOutput("rst_rsp_pc", rsp_pc, 32'd0);
      checkOutput("rst_rsp_fault", 32'(rsp_fault), 32'd0);
      checkOutput("rst_prog_ready", 32'(prog_ready), 32'd0);
    end else begin
      checkOutput("req_ready", 32'(req_ready),
                  32'((initEdges >= 256) && !prog_we && (!expValid || rsp_ready)));
      checkOutput("prog_ready", 32'(prog_ready), 32'(initEdges >= 256));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(expValid));
      if (expValid) begin
        checkOutput("rsp_instr", rsp_instr, expInstr);
        checkOutput("rsp_pc", rsp_pc, expPc);
        checkOutput("rsp_fault", 32'(rsp_fault), 32'(expFault));
      end
      if (logging && rsp_valid && rsp_ready) begin
        logPc.push_back(rsp_pc);
        logInstr.push_back(rsp_instr);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic rr,
                               input logic fl, input logic we, input logic [31:0] addr,
                               input logic [31:0] data);
    req_valid = v;
    req_pc    = pc;
    rsp_ready = rr;
    flush     = fl;
    prog_we   = we;
    prog_addr = addr;
    prog_data = data;
  endtask

  // Counts falling edges with req_ready low after reset release
  task automatic waitInit();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    checkOutput("init_cycles", 32'(n), 32'd256);
    @(posedge clk);
    #1;
  endtask

  // Single fetch; entered and left just after a rising edge
  task automatic doFetch(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [1:0] fault, input string name);
    int n;
    applyStimulus(1'b1, pc, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput({name, "_accept"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput({name, "_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({name, "_pc"}, rsp_pc, pc);
    checkOutput({name, "_instr"}, rsp_instr, instr);
    checkOutput({name, "_fault"}, 32'(rsp_fault), 32'(fault));
    @(posedge clk);
    #1;
  endtask

  task automatic doProgWrite(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, addr, data);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Hard stop if a scenario ever stalls beyond all bounds
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenario sequence
  initial begin
    streamPc    = '{32'h0, 32'h4, 32'h8};
    streamInstr = '{32'hA0A0_A0A0, 32'hB4B4_B4B4, 32'hC8C8_C8C8};
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    waitInit();

    doFetch(32'h0, NOP, 2'd0, "fill_0");
    doFetch(32'h3FC, NOP, 2'd0, "fill_3fc");

    doProgWrite(32'h10, 32'hDEAD_BEEF);
    doFetch(32'h10, 32'hDEAD_BEEF, 2'd0, "load_10");
    doFetch(32'h12, NOP, 2'd1, "misalign_12");
    doFetch(32'h400, NOP, 2'd2, "range_400");
    doFetch(32'hFFFF_FFFC, NOP, 2'd2, "range_top");
    doProgWrite(32'h400, 32'hCAFE_F00D);
    doFetch(32'h0, NOP, 2'd0, "word0_after_oob_write");

    doProgWrite(32'h0, 32'hA0A0_A0A0);
    doProgWrite(32'h4, 32'hB4B4_B4B4);
    doProgWrite(32'hB, 32'hC8C8_C8C8);

    logging = 1'b1;
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_pc", rsp_pc, 32'h0);
      checkOutput("stall_instr", rsp_instr, 32'hA0A0_A0A0);
      checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 logging = 1'b0;
    checkOutput("stream_count", 32'(logPc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < logPc.size()) begin
        checkOutput("stream_pc", logPc[i], streamPc[i]);
        checkOutput("stream_instr", logInstr[i], streamInstr[i]);
      end
    end

    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("flush_before_valid", 32'(rsp_valid), 32'd1);
    checkOutput("flush_before_pc", rsp_pc, 32'h4);
    @(posedge clk);
    #1 applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("flush_clear", 32'(rsp_valid), 32'd0);

    @(posedge clk);
    #1 applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("flush_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("flush_accept_valid", 32'(rsp_valid), 32'd1);
    checkOutput("flush_accept_pc", rsp_pc, 32'h8);
    checkOutput("flush_accept_instr", rsp_instr, 32'hC8C8_C8C8);
    @(negedge clk);
    checkOutput("flush_accept_drain", 32'(rsp_valid), 32'd0);

    @(posedge clk);
    #1 applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("pre_reset_valid", 32'(rsp_valid), 32'd1);
    checkOutput("pre_reset_instr", rsp_instr, 32'hDEAD_BEEF);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_async_drop", 32'(rsp_valid), 32'd0);
    checkOutput("reset_async_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    waitInit();
    doFetch(32'h10, NOP, 2'd0, "refill_10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_mem.md
# inst_fetch_mem

Parametrised, synchronous-read instruction memory with a valid/ready fetch interface. It sits between the PC/fetch stage and the decode stage, replacing the combinational ROM. It self-initialises to NOPs after reset, accepts a word-wide program-load port, and reports misaligned and out-of-range fetches as faults instead of returning garbage.

## Interface
- MEM_SIZE_BYTES, 1024: capacity in bytes; multiple of 4, power of two.
- ADDR_WIDTH, 32: width of byte addresses (PC, program address).
- NOP_WORD, 32'h0000_0013: fill value and faulted-response payload (ADDI x0,x0,0).
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  fetch request accepted this edge when high with req_valid.
- req_pc  in  ADDR_WIDTH  byte address of the instruction.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response this edge.
- rsp_instr  out  32  instruction word; byte at pc is the LSB.
- rsp_pc  out  ADDR_WIDTH  echo of the accepted req_pc.
- rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range.
- flush  in  1  discard the held response.
- prog_we  in  1  program-load word write.
- prog_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- prog_data  in  32  word to write; prog_data[7:0] lands at byte prog_addr.
- prog_ready  out  1  high only in RUN; prog_we is ignored while low.

## Operation
- FSM states are INIT and RUN. Reset forces INIT with the word counter at 0.
- INIT writes NOP_WORD to word counter, then increments it, once per edge. After word MEM_SIZE_BYTES/4-1 is written, the FSM moves to RUN. INIT never re-enters without reset.
- req_ready = RUN & ~prog_we & (~rsp_valid | rsp_ready).
  - A write cycle therefore blocks fetch, so read-during-write to the same word cannot occur.
- Request accept:
  - rsp_pc <= req_pc.
  - rsp_valid <= 1.
  - Fault priority: misaligned (req_pc[1:0] != 0) wins over out of range (req_pc > MEM_SIZE_BYTES-4).
  - A faulted request returns rsp_instr = NOP_WORD and does not read the array.
- No accept while rsp_ready is high clears rsp_valid. Otherwise the response holds stable (rsp_instr, rsp_pc, rsp_fault unchanged).
- Program write (RUN & prog_we): writes the word at prog_addr[log2(MEM_SIZE_BYTES)-1:2]. A prog_addr at or beyond MEM_SIZE_BYTES is dropped silently.
- flush:
  - With no accept in the same cycle, rsp_valid clears on the next edge.
  - With an accept in the same cycle, the new request's response is kept and the old one is dropped.
  - The accept condition itself ignores flush.
- Reset mid-operation:
  - rsp_valid drops immediately (asynchronous).
  - Any in-flight response is lost.
  - The array is fully re-filled with NOPs.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_instr NOP_WORD, rsp_pc 0, rsp_fault 00, prog_ready 0.
- INIT lasts MEM_SIZE_BYTES/4 edges after reset deasserts (256 for default). req_ready and prog_ready can first be high in the following cycle.
- Fetch latency is 1 cycle: accepted at edge N, rsp_valid high after edge N.
- Throughput is 1 instruction per cycle while rsp_ready stays high.
- A program write at edge N is visible to a request accepted at edge N+1 or later.
- req_ready is combinational from rsp_ready and prog_we. There are no other combinational paths from inputs to outputs.

## Structure
- Package inst_mem_pkg holds:
  - fault code constants FAULT_NONE / FAULT_MISALIGN / FAULT_RANGE;
  - the default NOP_WORD;
  - the INIT/RUN state encoding.
- Sub-module inst_mem_array: one write port and one synchronous read port, MEM_SIZE_BYTES/4 words of 32 bits, little-endian byte order within a word. The top level holds the FSM, init counter, fault checks and response register.

## Test plan
- Reset release, then poll -> req_ready 0 for exactly 256 cycles. Fetches of pc 0x0 and 0x3FC afterwards return 0x00000013, fault 00.
- Load prog_addr 0x10 with 0xDEADBEEF, then fetch 0x10 on the next cycle -> rsp_instr 0xDEADBEEF with 1-cycle latency. Fetch of 0x12 -> fault 01, instr 0x00000013.
- Fetch 0x400 and 0xFFFFFFFC -> fault 10. A prog write to 0x400 leaves word 0 unchanged.
- Back-to-back fetches 0x0, 0x4, 0x8 with rsp_ready held low for 3 cycles after the first response:
  - response 0x0 holds stable;
  - req_ready stays 0;
  - the stream resumes in order with no loss or duplication.
- flush with rsp_valid high and no request -> rsp_valid 0 next cycle. flush together with an accept of 0x8 -> only the 0x8 response appears.
- Assert reset mid-stream after a program load -> rsp_valid drops at once, INIT repeats, and the earlier-loaded word 0x10 reads back 0x00000013.
